// File: rtl/term_pkg.sv
// Shared constants, state encoding and helpers for the terminal controller.
package term_pkg;

  localparam int unsigned COLS   = 60;
  localparam int unsigned ROWS   = 17;
  localparam int unsigned X_W    = 6;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned ADDR_W = X_W + Y_W;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] DEL   = 8'h7F;

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  typedef enum logic [1:0] {
    CLRSCR,
    IDLE,
    WRITE,
    CLRLINE
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                  input logic [X_W-1:0] x);
    return {y, x};
  endfunction

  // 0x20-0x7E and 0x80-0xFF are glyphs; everything else is control.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= BLANK) && (b != DEL);
  endfunction

endpackage

// File: rtl/term_ctrl_if.sv
// Byte-stream input handshake plus VRAM write port and cursor position.
interface term_ctrl_if;
  import term_pkg::*;

  logic [7:0]        i_data;
  logic              i_valid;
  logic              o_ready;
  logic [ADDR_W-1:0] o_vram_addr;
  logic [7:0]        o_vram_data;
  logic              o_vram_ce;
  logic [X_W-1:0]    o_cur_x;
  logic [Y_W-1:0]    o_cur_y;

  // Controller side.
  modport slave (
    input  i_data, i_valid,
    output o_ready, o_vram_addr, o_vram_data, o_vram_ce, o_cur_x, o_cur_y
  );

  // Byte source / VRAM observer side.
  modport master (
    output i_data, i_valid,
    input  o_ready, o_vram_addr, o_vram_data, o_vram_ce, o_cur_x, o_cur_y
  );
endinterface

// File: rtl/term_sweep.sv
// x/y sweep counter over the visible area, row-only or full-screen.
module term_sweep
  import term_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           full,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           done
);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_LAST);
  assign y_end = !full || (y == Y_LAST);
  assign done  = en && x_end && y_end;

  // Advance x each enabled cycle; rows step only in full-screen mode.
  // Both counters return to zero after the last cell so the next sweep starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (!x_end) begin
        x <= x + 1'b1;
      end else begin
        x <= '0;
        if (full) y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/term_ctrl.sv
// Character-stream controller driving the text engine's VRAM write port.
module term_ctrl
  import term_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  term_ctrl_if.slave bus
);

  state_t         state, state_nx;
  logic           started;
  logic [X_W-1:0] cur_x, cur_x_nx;
  logic [Y_W-1:0] cur_y, cur_y_nx;
  logic [7:0]     char_q;
  logic           accept;
  logic           sw_en;
  logic [X_W-1:0] sw_x;
  logic [Y_W-1:0] sw_y;
  logic           sw_done;

  assign accept = (state == IDLE) && bus.i_valid;

  // The clear after reset must not write while reset is held; 'started'
  // holds the sweep and write enable off until the first edge after release.
  assign sw_en = started && ((state == CLRSCR) || (state == CLRLINE));

  term_sweep u_sweep (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (sw_en),
    .full  (state == CLRSCR),
    .x     (sw_x),
    .y     (sw_y),
    .done  (sw_done)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= CLRSCR;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
    end
  end

  // Cursor and latched character.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_x  <= '0;
      cur_y  <= '0;
      char_q <= BLANK;
    end else begin
      cur_x <= cur_x_nx;
      cur_y <= cur_y_nx;
      if (accept) char_q <= bus.i_data;
    end
  end

  // Next-state and cursor decode.
  always_comb begin
    state_nx = state;
    cur_x_nx = cur_x;
    cur_y_nx = cur_y;
    case (state)
      CLRSCR: begin
        if (sw_done) begin
          state_nx = IDLE;
          cur_x_nx = '0;
          cur_y_nx = '0;
        end
      end
      IDLE: begin
        if (accept) begin
          if (is_printable(bus.i_data)) begin
            state_nx = WRITE;
          end else begin
            case (bus.i_data)
              CR: cur_x_nx = '0;
              LF: begin
                cur_y_nx = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
                state_nx = CLRLINE;
              end
              BS: if (cur_x != '0) cur_x_nx = cur_x - 1'b1;
              FF: state_nx = CLRSCR;
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        if (cur_x == X_LAST) begin
          cur_x_nx = '0;
          cur_y_nx = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
          state_nx = CLRLINE;
        end else begin
          cur_x_nx = cur_x + 1'b1;
          state_nx = IDLE;
        end
      end
      CLRLINE: begin
        if (sw_done) state_nx = IDLE;
      end
      default: state_nx = CLRSCR;
    endcase
  end

  // VRAM port and handshake outputs; idle parks the address on the cursor.
  always_comb begin
    bus.o_ready     = 1'b0;
    bus.o_vram_ce   = 1'b0;
    bus.o_vram_data = BLANK;
    bus.o_vram_addr = pack_addr(cur_y, cur_x);
    case (state)
      CLRSCR: begin
        bus.o_vram_ce   = started;
        bus.o_vram_addr = pack_addr(sw_y, sw_x);
      end
      IDLE:    bus.o_ready = 1'b1;
      WRITE: begin
        bus.o_vram_ce   = 1'b1;
        bus.o_vram_data = char_q;
      end
      CLRLINE: begin
        bus.o_vram_ce   = 1'b1;
        bus.o_vram_addr = pack_addr(cur_y, sw_x);
      end
      default: ;
    endcase
  end

  assign bus.o_cur_x = cur_x;
  assign bus.o_cur_y = cur_y;

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl: vector table, directed corners, random stream.
module tb_term_ctrl;

  localparam int T_COLS = 60;
  localparam int T_ROWS = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  term_ctrl_if bus ();

  term_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mx = 0;
  int my = 0;
  int exp_q[$];
  int act_q[$];

  typedef struct {
    logic [7:0] data;
    int         ex;
    int         ey;
    int         nw;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int wr(input int y, input int x, input int d);
    return ((y * 64 + x) << 8) | d;
  endfunction

  task automatic model_newline();
    my = (my + 1) % T_ROWS;
    for (int x = 0; x < T_COLS; x++) exp_q.push_back(wr(my, x, 32));
  endtask

  task automatic model_clear();
    for (int y = 0; y < T_ROWS; y++)
      for (int x = 0; x < T_COLS; x++) exp_q.push_back(wr(y, x, 32));
    mx = 0;
    my = 0;
  endtask

  // Screen-level behaviour of one accepted byte: expected writes and new cursor.
  task automatic model_byte(input logic [7:0] b);
    exp_q.delete();
    if (b >= 8'h20 && b != 8'h7F) begin
      exp_q.push_back(wr(my, mx, int'(b)));
      if (mx == T_COLS - 1) begin
        mx = 0;
        model_newline();
      end else mx++;
    end else if (b == 8'h0D) mx = 0;
    else if (b == 8'h0A) model_newline();
    else if (b == 8'h08) begin
      if (mx > 0) mx--;
    end else if (b == 8'h0C) model_clear();
  endtask

  // Gather writes from now until o_ready; latency 1 means ready right away.
  task automatic collect(output int lat);
    int oor;
    oor = 0;
    act_q.delete();
    lat = 1;
    while (!bus.o_ready && lat <= 1100) begin
      if (bus.o_vram_ce) begin
        act_q.push_back(int'({bus.o_vram_addr, bus.o_vram_data}));
        if (bus.o_vram_addr[5:0] >= 6'd60) oor++;
      end
      step();
      lat++;
    end
    check("wr_x_in_range", oor, 0);
  endtask

  task automatic compare_writes(input string nm, input int lat);
    int nbad;
    int first;
    nbad = 0;
    first = -1;
    check({nm, "_wr_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] != exp_q[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    check($sformatf("%s_wr_bad(first@%0d)", nm, first), nbad, 0);
    check({nm, "_latency"}, lat, exp_q.size() + 1);
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_cur_x"}, int'(bus.o_cur_x), mx);
    check({nm, "_cur_y"}, int'(bus.o_cur_y), my);
    check({nm, "_idle_addr"}, int'(bus.o_vram_addr), my * 64 + mx);
    check({nm, "_idle_ce"}, int'(bus.o_vram_ce), 0);
  endtask

  // Present b, step through acceptance, then optionally keep i_valid high
  // with the following byte while the controller is busy.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] nb,
                           input bit hold, input string nm);
    int lat;
    check({nm, "_ready_pre"}, int'(bus.o_ready), 1);
    bus.i_data  = b;
    bus.i_valid = 1'b1;
    step();
    if (hold) bus.i_data = nb;
    else bus.i_valid = 1'b0;
    model_byte(b);
    collect(lat);
    compare_writes(nm, lat);
    check_idle(nm);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_addr"}, int'(bus.o_vram_addr), 0);
    check({nm, "_data"}, int'(bus.o_vram_data), 32);
    check({nm, "_ce"}, int'(bus.o_vram_ce), 0);
    check({nm, "_ready"}, int'(bus.o_ready), 0);
    check({nm, "_cur_x"}, int'(bus.o_cur_x), 0);
    check({nm, "_cur_y"}, int'(bus.o_cur_y), 0);
  endtask

  task automatic release_and_clear(input string nm);
    int lat;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check({nm, "_first_ce"}, int'(bus.o_vram_ce), 1);
    exp_q.delete();
    model_clear();
    collect(lat);
    compare_writes(nm, lat);
    check_idle(nm);
  endtask

  function automatic logic [7:0] gen();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'($urandom_range(32, 255));
    if (r < 68) return 8'h0D;
    if (r < 78) return 8'h0A;
    if (r < 86) return 8'h08;
    if (r < 88) return 8'h0C;
    return 8'($urandom_range(0, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] nb;
    bit hold;

    vt[0]  = '{8'h41, 1, 0, 1};
    vt[1]  = '{8'h0D, 0, 0, 0};
    vt[2]  = '{8'h08, 0, 0, 0};
    vt[3]  = '{8'h42, 1, 0, 1};
    vt[4]  = '{8'h08, 0, 0, 0};
    vt[5]  = '{8'h07, 0, 0, 0};
    vt[6]  = '{8'h7F, 0, 0, 0};
    vt[7]  = '{8'hE9, 1, 0, 1};
    vt[8]  = '{8'h0A, 1, 1, 60};
    vt[9]  = '{8'h1B, 1, 1, 0};
    vt[10] = '{8'h7E, 2, 1, 1};
    vt[11] = '{8'h0D, 0, 1, 0};

    bus.i_data  = 8'h00;
    bus.i_valid = 1'b0;
    repeat (3) step();
    check_reset_vals("rst");
    release_and_clear("boot_clr");

    // Table: first entry is 'A' at (0,0): one write of 0x000/0x41.
    for (int i = 0; i < 12; i++) begin
      send_byte(vt[i].data, 8'h00, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tab_x", i), int'(bus.o_cur_x), vt[i].ex);
      check($sformatf("vec%0d_tab_y", i), int'(bus.o_cur_y), vt[i].ey);
      check($sformatf("vec%0d_tab_nw", i), act_q.size(), vt[i].nw);
    end
    check("vec0_first_word", vt[0].nw, 1);

    // Form feed back to (0,0), then a full line of glyphs wraps onto row 1.
    send_byte(8'h0C, 8'h00, 1'b0, "ff");
    for (int i = 0; i < 60; i++)
      send_byte(8'h30 + 8'(i % 40), 8'h00, 1'b0, "line");
    check("wrap_last_char_addr", act_q[0] >> 8, 'h03B);
    check("wrap_clr_first_addr", act_q[1] >> 8, 'h040);
    check("wrap_clr_last_addr", act_q[60] >> 8, 'h07B);
    check("wrap_cur_x", int'(bus.o_cur_x), 0);
    check("wrap_cur_y", int'(bus.o_cur_y), 1);

    // Walk to (5,16); LF wraps to row 0 and clears it.
    for (int i = 0; i < 5; i++) send_byte(8'h61, 8'h00, 1'b0, "walk");
    for (int i = 0; i < 15; i++) send_byte(8'h0A, 8'h00, 1'b0, "walk_lf");
    check("at_5_16_y", int'(bus.o_cur_y), 16);
    send_byte(8'h0A, 8'h00, 1'b0, "lf_wrap");
    check("lf_wrap_x", int'(bus.o_cur_x), 5);
    check("lf_wrap_y", int'(bus.o_cur_y), 0);
    check("lf_wrap_first_addr", act_q[0] >> 8, 'h000);
    check("lf_wrap_last_addr", act_q[59] >> 8, 'h03B);
    send_byte(8'h0D, 8'h00, 1'b0, "cr");
    send_byte(8'h08, 8'h00, 1'b0, "bs0");
    check("bs0_x", int'(bus.o_cur_x), 0);

    // Back-to-back CR / BEL with i_valid held high.
    for (int i = 0; i < 3; i++) send_byte(8'h78, 8'h00, 1'b0, "pre_b2b");
    bus.i_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.i_data = (i % 2 == 0) ? 8'h0D : 8'h07;
      check("b2b_ready", int'(bus.o_ready), 1);
      step();
      model_byte(bus.i_data);
      check("b2b_ce", int'(bus.o_vram_ce), 0);
      check("b2b_x", int'(bus.o_cur_x), 0);
    end
    bus.i_valid = 1'b0;
    check_idle("b2b_end");

    // Random stream, sometimes holding the next byte during busy periods.
    b = gen();
    for (int k = 0; k < 200; k++) begin
      nb = gen();
      hold = ($urandom_range(0, 1) == 1) && (k < 199);
      send_byte(b, nb, hold, "rnd");
      if (!hold) repeat ($urandom_range(0, 2)) step();
      b = nb;
    end
    bus.i_valid = 1'b0;

    // FF then reset in the middle of the clear.
    send_byte(8'h41, 8'h00, 1'b0, "pre_ff");
    bus.i_data  = 8'h0C;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    repeat (100) step();
    check("midclr_ce", int'(bus.o_vram_ce), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) step();
    check_reset_vals("held_rst");
    mx = 0;
    my = 0;
    release_and_clear("restart_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
